// File: rtl/up_counter_pkg.sv
// up_counter_pkg
// Shared definitions for the 32-bit up counter slice.
//   state_t       : controller states (IDLE, RUN, DONE)
//   MODE_WRAP     : auto-reload to RESET_VALUE at the terminal count
//   MODE_ONESHOT  : stop at the terminal count and park in DONE
//   DEFAULT_WIDTH : default counter / compare width
package up_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

endpackage : up_counter_pkg

// File: rtl/up_counter_fsm.sv
// up_counter_fsm
// Control half of the up counter: state register plus tc/done/busy.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request IDLE/DONE -> RUN (ignored while in RUN)
//   load      : parallel load in the datapath; blocks every other command
//   clear     : return to IDLE
//   term_hit  : datapath reports an enabled edge in RUN with out == limit
//   mode      : MODE_WRAP or MODE_ONESHOT
//   tc        : registered one-cycle terminal-count pulse
//   done      : high while in DONE
//   busy      : high while in RUN
module up_counter_fsm
  import up_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic load,
  input  logic clear,
  input  logic term_hit,
  input  logic mode,
  output logic tc,
  output logic done,
  output logic busy
);

  state_t state_reg, state_next;
  logic   tc_reg, tc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tc_reg    <= tc_next;
    end
  end

  // Command priority: load > clear > start > count. A load or clear on the
  // terminal edge swallows the tc pulse.
  always_comb begin
    state_next = state_reg;
    tc_next    = 1'b0;
    if (load) begin
      state_next = state_reg;
    end else if (clear) begin
      state_next = IDLE;
    end else if (start && (state_reg != RUN)) begin
      state_next = RUN;
    end else if (term_hit && (state_reg == RUN)) begin
      tc_next = 1'b1;
      if (mode == MODE_ONESHOT) begin
        state_next = DONE;
      end
    end
  end

  // Decoded straight from the state register, so still free of any
  // combinational path from the inputs.
  assign done = (state_reg == DONE);
  assign busy = (state_reg == RUN);
  assign tc   = tc_reg;

endmodule : up_counter_fsm

// File: rtl/up_counter_32bit.sv
// up_counter_32bit
// Programmable up counter with load, enable, terminal-count compare and
// wrap / one-shot modes. Datapath (out register, incrementer, compare, ovf)
// lives here; sequencing lives in up_counter_fsm.
// Parameters:
//   WIDTH       : counter and compare width
//   RESET_VALUE : value placed in out on reset, clear and restart from DONE
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : count enable (effective only in RUN)
//   start     : IDLE/DONE -> RUN request
//   clear     : out <= RESET_VALUE, state IDLE, ovf cleared
//   load      : out <= load_val, state unchanged
//   load_val  : parallel load value
//   limit     : terminal count, sampled every cycle
//   mode      : 0 = wrap, 1 = one-shot
//   out       : current count
//   tc        : one-cycle terminal-count pulse
//   done      : high while in DONE
//   ovf       : sticky, set when the count rolls from all-ones to zero
//   busy      : high while in RUN
module up_counter_32bit
  import up_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic             ovf,
  output logic             busy
);

  logic [WIDTH-1:0] out_reg, out_next;
  logic             ovf_reg, ovf_next;
  logic             at_limit;
  logic             count_edge;
  logic             term_hit;

  assign at_limit   = (out_reg == limit);
  assign count_edge = busy && en;
  assign term_hit   = count_edge && at_limit;

  up_counter_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load     (load),
    .clear    (clear),
    .term_hit (term_hit),
    .mode     (mode),
    .tc       (tc),
    .done     (done),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= RESET_VALUE;
      ovf_reg <= 1'b0;
    end else begin
      out_reg <= out_next;
      ovf_reg <= ovf_next;
    end
  end

  // Same priority order as the controller. A start in IDLE leaves out
  // alone; a start in DONE restarts from RESET_VALUE. A count above limit
  // simply keeps climbing and rolls through zero, which sets ovf.
  always_comb begin
    out_next = out_reg;
    ovf_next = ovf_reg;
    if (load) begin
      out_next = load_val;
    end else if (clear) begin
      out_next = RESET_VALUE;
      ovf_next = 1'b0;
    end else if (start && done) begin
      out_next = RESET_VALUE;
    end else if (count_edge) begin
      if (at_limit) begin
        // One-shot holds at limit; wrap reloads.
        if (mode == MODE_WRAP) begin
          out_next = RESET_VALUE;
        end
      end else begin
        out_next = out_reg + 1'b1;
        if (&out_reg) begin
          ovf_next = 1'b1;
        end
      end
    end
  end

  assign out = out_reg;
  assign ovf = ovf_reg;

endmodule : up_counter_32bit

// File: doc/up_counter_32bit.md
# up_counter_32bit

Programmable 32-bit up counter with load, enable, terminal-count compare and wrap/one-shot modes. It is the count-up companion to the existing 32-bit down counter in the Ngveri digital model library. It is intended for timers, event counters and period generators driven from the mixed-signal simulation.

## Interface
- WIDTH, 32, counter and compare width
- RESET_VALUE, 0, value loaded into `out` on reset and on clear
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable; counts only in RUN
- start  in  1  single-cycle request: IDLE/DONE -> RUN
- clear  in  1  `out` <= RESET_VALUE, state -> IDLE, `ovf` cleared
- load  in  1  `out` <= `load_val`; state unchanged
- load_val  in  WIDTH  parallel load value
- limit  in  WIDTH  terminal count value, sampled every cycle
- mode  in  1  0 = wrap (auto-reload to RESET_VALUE), 1 = one-shot (stop at limit)
- out  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered, one cycle
- done  out  1  high while in DONE
- ovf  out  1  sticky: count passed all-ones and wrapped to 0
- busy  out  1  high while in RUN

## Operation
- States:
  - IDLE: hold `out`.
  - RUN: `out` <= `out`+1 when `en`.
  - DONE: hold `out`.
- Priority per edge: rst > load > clear > start > count.
- rst: `out`=RESET_VALUE, state IDLE, `tc`=0, `done`=0, `ovf`=0, `busy`=0.
- start:
  - In IDLE: -> RUN, `out` unchanged.
  - In DONE: -> RUN, `out` <= RESET_VALUE.
  - Ignored in RUN.
- Terminal condition, in RUN: `en` && `out`==`limit`.
  - mode 0: `out` <= RESET_VALUE, stay RUN, `tc` pulses.
  - mode 1: `out` holds `limit`, -> DONE, `tc` pulses.
- `out` > `limit` (after a load or a `limit` change): keeps counting upward. At all-ones with `en`, `out` <= 0 and `ovf` <= 1. The terminal condition is then reached normally.
- `limit`==`out` on the same edge a load occurs: the load wins, with no `tc`.
- load during RUN: the new value appears next cycle; counting resumes from it.
- load in DONE: `out` is updated and the state stays DONE.
- `en` low in RUN: `out` holds and no `tc`; the state is unaffected.
- Arithmetic: unsigned modulo 2^WIDTH.
- `limit`==RESET_VALUE in mode 0: `tc` every enabled cycle and `out` stays RESET_VALUE.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Latency from an enabled edge to the new `out`: 1 cycle.
- `tc` is high for exactly the one cycle after the terminal edge, aligned with `out`=RESET_VALUE (mode 0) or `done`=1 (mode 1).
- `start` -> `busy`=1 on the next cycle. The first increment occurs on the following edge if `en`.
- clear or rst mid-count takes effect on that edge. A pending `tc` is suppressed.

## Structure
- Package `up_counter_pkg`:
  - state enum (IDLE, RUN, DONE)
  - mode constants MODE_WRAP=0, MODE_ONESHOT=1
  - default WIDTH
- Sub-module `up_counter_fsm`: owns the state register and the `done`/`busy`/`tc` generation, taking `term_hit` and the command inputs.
- The top level holds the datapath: `out` register, incrementer, compare and `ovf`.

## Test plan
- Reset: rst=1 for 2 cycles -> `out`=0, `tc`=`done`=`ovf`=`busy`=0.
- Wrap mode: `limit`=5, mode 0, start, `en`=1 -> `out` 0,1,2,3,4,5,0. `tc`=1 only in the cycle `out` returns to 0. `busy` stays 1.
- One-shot: `limit`=3, mode 1 -> `out` 0..3 then holds 3, `done`=1, `tc` one pulse. A second start gives `out`=0 and RUN.
- Overflow: load 0xFFFFFFFE with `limit`=2, `en`=1 -> `out` FFFFFFFF, 0 (`ovf`=1), 1, 2 then `tc`. clear -> `ovf`=0, `out`=0, IDLE.
- Priority: load=1, clear=1 and start=1 on the same edge with `load_val`=0x10 -> `out`=0x10, state unchanged. `en` toggling 1,0,1 -> `out` holds during `en`=0.
- Reset mid-run: rst at `out`=4, `limit`=4 -> no `tc`, `out`=0, IDLE.
